// File: rtl/tea_block_engine.sv
// Iterative TEA block cipher engine: one full round per clock, encrypt or decrypt
// selected per block, with valid/ready handshakes on both sides.
module tea_block_engine #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [31:0]  in_v0,
    input  logic [31:0]  in_v1,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_v0,
    output logic [31:0]  out_v1,
    output logic         out_mode,
    output logic         busy
);

    localparam int unsigned    CW      = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0]  LAST    = CW'(ROUNDS - 1);
    localparam logic [31:0]    DEC_SUM = 32'(DELTA * ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   sum, v0, v1;
    logic [31:0]   k0, k1, k2, k3;

    logic [31:0] s_enc, v0_enc, v1_enc, v0_dec, v1_dec;
    logic [31:0] v0_nxt, v1_nxt, sum_nxt;

    function automatic logic [31:0] tea_f(input logic [31:0] x, s, ka, kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // Both directions are computed every cycle; the latched mode picks one.
    always_comb begin
        s_enc   = sum + DELTA;
        v0_enc  = v0 + tea_f(v1, s_enc, k0, k1);
        v1_enc  = v1 + tea_f(v0_enc, s_enc, k2, k3);
        v1_dec  = v1 - tea_f(v0, sum, k2, k3);
        v0_dec  = v0 - tea_f(v1_dec, sum, k0, k1);
        v0_nxt  = out_mode ? v0_dec : v0_enc;
        v1_nxt  = out_mode ? v1_dec : v1_enc;
        sum_nxt = out_mode ? (sum - DELTA) : s_enc;
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // mixing in blocking assignments would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            sum       <= '0;
            v0        <= '0;
            v1        <= '0;
            k0        <= '0;
            k1        <= '0;
            k2        <= '0;
            k3        <= '0;
            out_v0    <= '0;
            out_v1    <= '0;
            out_mode  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        v0       <= in_v0;
                        v1       <= in_v1;
                        k0       <= key[127:96];
                        k1       <= key[95:64];
                        k2       <= key[63:32];
                        k3       <= key[31:0];
                        out_mode <= mode;
                        cnt      <= '0;
                        sum      <= mode ? DEC_SUM : 32'h0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    v0  <= v0_nxt;
                    v1  <= v1_nxt;
                    sum <= sum_nxt;
                    cnt <= cnt + 1'b1;
                    // Final round: publish the words directly so they appear with out_valid.
                    if (cnt == LAST) begin
                        out_v0    <= v0_nxt;
                        out_v1    <= v1_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_block_engine.sv
// Scoreboard bench for tea_block_engine: three instances (ROUNDS = 32, 1, 8)
// share the clock and reset; expected words come from a behavioural TEA model.
module tb_tea_block_engine;

    localparam int          NI       = 3;
    localparam logic [31:0] TB_DELTA = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic         mode      [NI];
    logic [31:0]  in_v0     [NI];
    logic [31:0]  in_v1     [NI];
    logic [127:0] key       [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [31:0]  out_v0    [NI];
    logic [31:0]  out_v1    [NI];
    logic         out_mode  [NI];
    logic         busy      [NI];

    typedef struct {
        logic [63:0] v;
        logic        m;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    tea_block_engine #(.ROUNDS(32)) dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode[0]), .in_v0(in_v0[0]), .in_v1(in_v1[0]), .key(key[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_v0(out_v0[0]),
        .out_v1(out_v1[0]), .out_mode(out_mode[0]), .busy(busy[0])
    );

    tea_block_engine #(.ROUNDS(1)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode[1]), .in_v0(in_v0[1]), .in_v1(in_v1[1]), .key(key[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_v0(out_v0[1]),
        .out_v1(out_v1[1]), .out_mode(out_mode[1]), .busy(busy[1])
    );

    tea_block_engine #(.ROUNDS(8)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mode(mode[2]), .in_v0(in_v0[2]), .in_v1(in_v1[2]), .key(key[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_v0(out_v0[2]),
        .out_v1(out_v1[2]), .out_mode(out_mode[2]), .busy(busy[2])
    );

    function automatic int rounds_of(input int idx);
        case (idx)
            0:       return 32;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Decrypt starting sums written out as independent constants.
    function automatic logic [31:0] dec_sum_of(input int idx);
        case (idx)
            0:       return 32'hC6EF3720;
            1:       return 32'h9E3779B9;
            default: return 32'hF1BBCDC8;
        endcase
    endfunction

    function automatic logic [31:0] sum_of(input int idx);
        case (idx)
            0:       return dut0.sum;
            1:       return dut1.sum;
            default: return dut2.sum;
        endcase
    endfunction

    function automatic logic [63:0] tea_model(input logic [31:0] a_in, b_in,
                                              input logic [127:0] k, input logic m,
                                              input int r);
        logic [31:0] a, b, s, k0, k1, k2, k3;
        a  = a_in;
        b  = b_in;
        k0 = k[127:96];
        k1 = k[95:64];
        k2 = k[63:32];
        k3 = k[31:0];
        if (!m) begin
            s = 32'h0;
            for (int i = 0; i < r; i++) begin
                s = s + TB_DELTA;
                a = a + (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
                b = b + (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
            end
        end else begin
            s = 32'h0;
            for (int i = 0; i < r; i++) s = s + TB_DELTA;
            for (int i = 0; i < r; i++) begin
                b = b - (((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3));
                a = a - (((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1));
                s = s - TB_DELTA;
            end
        end
        return {a, b};
    endfunction

    // Present one block, check sum/latency/stall behaviour, consume and score it.
    task automatic run_block(input int idx, input logic [31:0] a, b, input logic [127:0] k,
                             input logic m, input int stall, input bit disturb,
                             output logic [31:0] r0, r1);
        sb_t         e;
        int          n;
        bit          seen, ok, quiet;
        logic [31:0] h0, h1, end_sum;
        r0 = 32'h0;
        r1 = 32'h0;
        @(negedge clk);
        in_v0[idx]     = a;
        in_v1[idx]     = b;
        key[idx]       = k;
        mode[idx]      = m;
        in_valid[idx]  = 1'b1;
        out_ready[idx] = 1'b0;
        n = 0;
        while (in_ready[idx] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_wait[%0d]: in_ready=%b required 1 within 100 cycles", idx, in_ready[idx]);
            in_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        e.v = tea_model(a, b, k, m, rounds_of(idx));
        e.m = m;
        sbq.push_back(e);
        #1;
        in_valid[idx] = 1'b0;

        checks++;
        if (sum_of(idx) !== (m ? dec_sum_of(idx) : 32'h0)) begin
            errors++;
            $display("FAIL start_sum[%0d]: got %h required %h", idx, sum_of(idx),
                     m ? dec_sum_of(idx) : 32'h0);
        end
        checks++;
        if (busy[idx] !== 1'b1 || in_ready[idx] !== 1'b0 || out_mode[idx] !== m) begin
            errors++;
            $display("FAIL run_flags[%0d]: busy=%b in_ready=%b out_mode=%b required 1 0 %b",
                     idx, busy[idx], in_ready[idx], out_mode[idx], m);
        end

        n     = 1;
        seen  = 1'b0;
        quiet = 1'b1;
        while (!seen && n <= 400) begin
            if (disturb) begin
                in_v0[idx]    = ~in_v0[idx];
                key[idx]      = key[idx] ^ {4{32'hA5A5A5A5}};
                mode[idx]     = ~mode[idx];
                in_valid[idx] = ~in_valid[idx];
            end
            @(posedge clk);
            #1;
            if (in_ready[idx] !== 1'b0) quiet = 1'b0;
            if (out_valid[idx] === 1'b1) seen = 1'b1;
            else n++;
        end
        in_valid[idx] = 1'b0;
        checks++;
        if (!seen || n != rounds_of(idx)) begin
            errors++;
            $display("FAIL latency[%0d]: got %0d edges required %0d", idx, n, rounds_of(idx));
            if (!seen) begin
                void'(sbq.pop_front());
                return;
            end
        end
        if (disturb) begin
            checks++;
            if (!quiet) begin
                errors++;
                $display("FAIL busy_in_ready[%0d]: in_ready rose during RUN required 0", idx);
            end
        end
        end_sum = m ? 32'h0 : dec_sum_of(idx);
        checks++;
        if (sum_of(idx) !== end_sum) begin
            errors++;
            $display("FAIL end_sum[%0d]: got %h required %h", idx, sum_of(idx), end_sum);
        end

        if (stall > 0) begin
            h0 = out_v0[idx];
            h1 = out_v1[idx];
            ok = 1'b1;
            repeat (stall) begin
                @(posedge clk);
                #1;
                if (out_v0[idx] !== h0 || out_v1[idx] !== h1 || out_valid[idx] !== 1'b1 ||
                    in_ready[idx] !== 1'b0 || busy[idx] !== 1'b1) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stall[%0d]: v=%h_%h valid=%b in_ready=%b required %h_%h 1 0",
                         idx, out_v0[idx], out_v1[idx], out_valid[idx], in_ready[idx], h0, h1);
            end
        end

        out_ready[idx] = 1'b1;
        r0 = out_v0[idx];
        r1 = out_v1[idx];
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b0;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard[%0d]: output with no expected entry", idx);
        end else begin
            e = sbq.pop_front();
            if ({r0, r1} !== e.v || out_mode[idx] !== e.m) begin
                errors++;
                $display("FAIL result[%0d]: got %h mode %b required %h mode %b",
                         idx, {r0, r1}, out_mode[idx], e.v, e.m);
            end
        end
        checks++;
        if (out_valid[idx] !== 1'b0 || busy[idx] !== 1'b0 || in_ready[idx] !== 1'b1 ||
            out_v0[idx] !== r0 || out_v1[idx] !== r1) begin
            errors++;
            $display("FAIL post_handshake[%0d]: valid=%b busy=%b in_ready=%b v=%h_%h required 0 0 1 %h_%h",
                     idx, out_valid[idx], busy[idx], in_ready[idx], out_v0[idx], out_v1[idx], r0, r1);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            mode[i]      = 1'b0;
            in_v0[i]     = 32'h0;
            in_v1[i]     = 32'h0;
            key[i]       = 128'h0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || in_ready[i] !== 1'b1 ||
                out_mode[i] !== 1'b0 || out_v0[i] !== 32'h0 || out_v1[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: valid=%b busy=%b in_ready=%b mode=%b v=%h_%h required 0 0 1 0 0_0",
                         i, out_valid[i], busy[i], in_ready[i], out_mode[i], out_v0[i], out_v1[i]);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_encrypt_vector();
        logic [31:0] r0, r1;
        run_block(0, 32'h0, 32'h0, 128'h0, 1'b0, 0, 1'b0, r0, r1);
        checks++;
        if (r0 !== 32'h41EA3A0A || r1 !== 32'h94BAA940) begin
            errors++;
            $display("FAIL enc_vector: got %h_%h required 41ea3a0a_94baa940", r0, r1);
        end
    endtask

    task automatic test_decrypt_vector();
        logic [31:0] r0, r1;
        run_block(0, 32'h41EA3A0A, 32'h94BAA940, 128'h0, 1'b1, 0, 1'b0, r0, r1);
        checks++;
        if (r0 !== 32'h0 || r1 !== 32'h0) begin
            errors++;
            $display("FAIL dec_vector: got %h_%h required 0_0", r0, r1);
        end
    endtask

    task automatic test_round_trip_backpressure();
        logic [31:0]  c0, c1, p0, p1;
        logic [127:0] k;
        k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        run_block(0, 32'h01234567, 32'h89ABCDEF, k, 1'b0, 10, 1'b0, c0, c1);
        run_block(0, c0, c1, k, 1'b1, 3, 1'b0, p0, p1);
        checks++;
        if (p0 !== 32'h01234567 || p1 !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL round_trip: got %h_%h required 01234567_89abcdef", p0, p1);
        end
    endtask

    task automatic test_operand_isolation();
        logic [31:0]  q0, q1, d0, d1;
        logic [127:0] k;
        k = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
        run_block(0, 32'hA5A55A5A, 32'h3C3CC3C3, k, 1'b0, 0, 1'b0, q0, q1);
        run_block(0, 32'hA5A55A5A, 32'h3C3CC3C3, k, 1'b0, 0, 1'b1, d0, d1);
        checks++;
        if (d0 !== q0 || d1 !== q1) begin
            errors++;
            $display("FAIL isolation: got %h_%h required %h_%h", d0, d1, q0, q1);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL extra_accept: busy=%b valid=%b required 0 0", busy[0], out_valid[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r0, r1;
        @(negedge clk);
        in_v0[0]    = 32'h11112222;
        in_v1[0]    = 32'h33334444;
        key[0]      = 128'h1;
        mode[0]     = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
            out_v0[0] !== 32'h0 || out_v1[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_run_reset: valid=%b busy=%b in_ready=%b v=%h_%h required 0 0 1 0_0",
                     out_valid[0], busy[0], in_ready[0], out_v0[0], out_v1[0]);
        end
        run_block(0, 32'h55667788, 32'h99AABBCC, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                  1'b0, 0, 1'b0, r0, r1);
    endtask

    task automatic test_param_sweep();
        logic [31:0]  c0, c1, p0, p1;
        logic [127:0] k;
        k = 128'h2BD6459F_82C5B300_952C4910_4881FF48;
        for (int idx = 1; idx < NI; idx++) begin
            run_block(idx, 32'hDEADBEEF, 32'h0BADF00D, k, 1'b0, 2, 1'b0, c0, c1);
            run_block(idx, c0, c1, k, 1'b1, 0, 1'b0, p0, p1);
            checks++;
            if (p0 !== 32'hDEADBEEF || p1 !== 32'h0BADF00D) begin
                errors++;
                $display("FAIL sweep_round_trip[%0d]: got %h_%h required deadbeef_0badf00d", idx, p0, p1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_round_trip_backpressure();
        test_operand_isolation();
        test_reset_mid_run();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
